// File: rtl/key_dir_queue.sv
// key_dir_queue: edge-detected direction-key FIFO drained one command per vsync frame
module key_dir_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [7:0]                 keycode,
    input  logic                       frame_clk,
    output logic [7:0]                 keycode_out,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       q_empty,
    output logic                       q_full,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [7:0]    key_prev, last_cmd;
    logic          sync1, sync2, sync3;
    logic          valid, press, accept, frame_tick, push, drop;
    logic [CW-1:0] count_next;

    // press detection, frame edge detection and queue push/pop decisions
    always_comb begin
        valid      = (keycode == 8'd26) || (keycode == 8'd22) || (keycode == 8'd4) || (keycode == 8'd7);
        press      = valid && (keycode != key_prev);
        accept     = press && (keycode != last_cmd);
        frame_tick = sync2 && !sync3;
        push       = accept && (!q_full || frame_tick);
        drop       = accept && q_full && !frame_tick;
        count_next = q_count + CW'(push) - CW'(frame_tick && !q_empty);
    end

    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == CW'(DEPTH));

    // queue storage is not reset; only entries below q_count are ever read
    always_ff @(posedge Clk) begin
        if (push) mem[tail] <= keycode;
    end

    // control state: synchronizer, pointers, count, output command and flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            head        <= '0;
            tail        <= '0;
            q_count     <= '0;
            keycode_out <= 8'd0;
            overflow    <= 1'b0;
            key_prev    <= 8'd0;
            last_cmd    <= 8'd0;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
        end else begin
            key_prev <= keycode;
            sync1    <= frame_clk;
            sync2    <= sync1;
            sync3    <= sync2;
            q_count  <= count_next;
            if (push) begin
                tail     <= tail + AW'(1);
                last_cmd <= keycode;
            end
            if (frame_tick) begin
                keycode_out <= q_empty ? 8'd0 : mem[head];
                if (!q_empty) head <= head + AW'(1);
            end
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_key_dir_queue.sv
// tb_key_dir_queue: directed checks of press filtering, frame draining, overflow and reset
module tb_key_dir_queue;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'd0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode_out;
    logic [2:0] q_count;
    logic       q_empty, q_full, overflow;
    int checks = 0;
    int errors = 0;

    key_dir_queue #(.DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
        .keycode_out(keycode_out), .q_count(q_count), .q_empty(q_empty),
        .q_full(q_full), .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        keycode = 8'd0;
        frame_clk = 1'b0;
        tick(2);
        Reset = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        tick(1);
    endtask

    // frame pulse: keycode_out has updated once this returns
    task automatic pulse();
        frame_clk = 1'b1;
        tick(3);
        frame_clk = 1'b0;
        tick(3);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, q_empty, 1);
        chk({tag, "_full"}, q_full, 0);
        chk({tag, "_count"}, q_count, 0);
        chk({tag, "_out"}, keycode_out, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        do_reset();
        chk_reset_state("rst");

        // single held press, then latency of one frame pulse
        press(8'd26);
        chk("single_cnt1", q_count, 1);
        tick(100);
        chk("held_cnt1", q_count, 1);
        frame_clk = 1'b1;
        tick(2);
        chk("lat_2edges", keycode_out, 0);
        tick(1);
        chk("lat_3edges", keycode_out, 26);
        chk("single_cnt0", q_count, 0);
        frame_clk = 1'b0;
        tick(10);
        chk("out_hold", keycode_out, 26);

        // ordered sequence
        do_reset();
        press(8'd4); press(8'd0); press(8'd7); press(8'd0); press(8'd22);
        chk("seq_cnt", q_count, 3);
        pulse(); chk("seq_1", keycode_out, 4);
        pulse(); chk("seq_2", keycode_out, 7);
        pulse(); chk("seq_3", keycode_out, 22);
        pulse(); chk("seq_empty", keycode_out, 0);
        chk("seq_q_empty", q_empty, 1);

        // duplicate drop
        do_reset();
        press(8'd7); press(8'd0); press(8'd7);
        chk("dup_cnt", q_count, 1);
        chk("dup_ovf", overflow, 0);

        // invalid keys never enqueue
        do_reset();
        press(8'd5); press(8'd0); press(8'd27);
        chk("inval_cnt", q_count, 0);

        // overflow
        do_reset();
        press(8'd26); press(8'd4); press(8'd22); press(8'd7);
        chk("full_ovf0", overflow, 0);
        press(8'd26);
        chk("ovf_full", q_full, 1);
        chk("ovf_cnt", q_count, 4);
        chk("ovf_flag", overflow, 1);
        keycode = 8'd0;
        pulse(); chk("drain_1", keycode_out, 26);
        pulse(); chk("drain_2", keycode_out, 4);
        pulse(); chk("drain_3", keycode_out, 22);
        pulse(); chk("drain_4", keycode_out, 7);
        chk("drain_empty", q_empty, 1);
        chk("ovf_sticky", overflow, 1);

        // push on full coinciding with pop, then wrapped drain
        do_reset();
        press(8'd26); press(8'd4); press(8'd22); press(8'd7);
        frame_clk = 1'b1;
        tick(2);
        keycode = 8'd26;
        tick(1);
        chk("fullpp_out", keycode_out, 26);
        chk("fullpp_cnt", q_count, 4);
        chk("fullpp_ovf", overflow, 0);
        frame_clk = 1'b0;
        tick(3);
        pulse(); chk("wrap_1", keycode_out, 4);
        pulse(); chk("wrap_2", keycode_out, 22);
        pulse(); chk("wrap_3", keycode_out, 7);
        pulse(); chk("wrap_4", keycode_out, 26);
        chk("wrap_cnt", q_count, 0);

        // push coinciding with pop on an empty queue
        do_reset();
        frame_clk = 1'b1;
        tick(2);
        keycode = 8'd4;
        tick(1);
        chk("simul_out", keycode_out, 0);
        chk("simul_cnt", q_count, 1);
        frame_clk = 1'b0;
        tick(3);
        pulse();
        chk("simul_next", keycode_out, 4);

        // mid-operation reset
        do_reset();
        press(8'd22);
        pulse();
        press(8'd26); press(8'd4); press(8'd7);
        chk("mid_cnt", q_count, 3);
        chk("mid_out", keycode_out, 22);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        keycode = 8'd0;
        chk_reset_state("mid_rst");
        tick(1);
        pulse();
        chk("mid_after", keycode_out, 0);
        chk("mid_after_cnt", q_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
